split_frame_length: RTL and testbench
=====================================

Name: split_frame_length

Overview:
- Inverse of the frame-length merger. Takes one AXI4-Stream carrying [frame-length header][Ethernet frame].
- Splits it into two streams: a frame-length-only stream and a header-free Ethernet frame stream.
- Counts delivered payload bytes against the header value and flags a mismatch.
- Sits at the egress of ATS/TSN queues, ahead of logic that consumes the length and the frame separately.

Parameters:
- DATA_WIDTH, 8, tdata width in bits; multiple of 8.
- FRAME_LENGTH_WIDTH, 16, header width in bits; multiple of DATA_WIDTH.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width (derived localparam).
- FRAME_LENGTH_BEAT_NUM, FRAME_LENGTH_WIDTH/DATA_WIDTH, header beats (derived localparam).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  merged stream data
- s_axis_tkeep  in  KEEP_WIDTH  byte enables (ignored on header beats)
- s_axis_tvalid  in  1  valid
- s_axis_tready  out  1  ready
- s_axis_tlast  in  1  end of frame (last payload beat)
- m_axis_frame_length_tdata  out  DATA_WIDTH  header beat, LSB chunk first
- m_axis_frame_length_tvalid  out  1  valid
- m_axis_frame_length_tready  in  1  ready
- m_axis_frame_length_tlast  out  1  high on header beat FRAME_LENGTH_BEAT_NUM-1
- m_axis_tdata  out  DATA_WIDTH  Ethernet frame data
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  valid
- m_axis_tready  in  1  ready
- m_axis_tlast  out  1  end of frame
- frame_length  out  FRAME_LENGTH_WIDTH  header value of the current/last frame
- length_error  out  1  one-cycle pulse on byte-count mismatch or truncated header

Behaviour:
- Reset: rstn low clears asynchronously. All tvalid=0, tdata/tkeep/tlast=0, frame_length=0, length_error=0, state=HEADER, header counter=0, byte counter=0. A frame in flight at reset is discarded.
- States:
  - HEADER: counter hdr_cnt runs 0..FRAME_LENGTH_BEAT_NUM-1. Each accepted beat is routed to the frame-length output register. It is also written into frame_length bits [DATA_WIDTH*hdr_cnt +: DATA_WIDTH]; byte order is little-endian, LSB first. On acceptance of beat FRAME_LENGTH_BEAT_NUM-1: set m_axis_frame_length_tlast, clear byte counter, go to PAYLOAD.
  - PAYLOAD: accepted beats go to the frame output register unchanged (tdata, tkeep, tlast). byte_cnt += popcount(tkeep). byte_cnt width is FRAME_LENGTH_WIDTH and it saturates at all-ones. On an accepted beat with tlast: compare byte_cnt including that beat against frame_length. If they differ, pulse length_error on the next cycle. Go to HEADER with hdr_cnt=0.
- s_axis_tlast during HEADER (truncated header): the beat is still forwarded on the length stream with m_axis_frame_length_tlast=1, and length_error pulses. State stays HEADER with hdr_cnt=0. Nothing is emitted on the frame stream.
- Output registers: each output has a one-entry output register, so latency is 1 cycle from s handshake to m valid.
- s_axis_tready = (target register empty) OR (target m_tready high), where the target is chosen by the current state. The non-target output never blocks. Full throughput is one beat/cycle when the target sink is ready.
- AXI rules: m tvalid holds and m data stays stable until the handshake. s_axis_tready does not depend on s_axis_tvalid.
- frame_length holds its value from header completion until the next header's first beat overwrites its low chunk.
- FRAME_LENGTH_BEAT_NUM=1: HEADER is a single beat; the counter logic degenerates cleanly.

Decomposition:
- Include header: FRAME_LENGTH_WIDTH default, beat-count and counter-width derivations, state encodings HEADER=0 and PAYLOAD=1. These are shared with the merger and the pcap bench utilities.
- One sub-module: axis_output_register, a one-entry AXIS register slice parameterised on DATA_WIDTH/KEEP_WIDTH. It is instantiated twice; the length instance ties tkeep off.

Test Plan:
- DATA_WIDTH=8, input 0xEE,0x05 then a 1518-byte pcap frame -> length stream 0xEE then 0x05 with tlast on 0x05; frame stream 1518 beats matching the pcap with tlast on the last; frame_length=1518; length_error never asserts.
- Same traffic, m_axis_tready toggling every 50 cycles and length tready held low 20 cycles -> no data loss or duplication; s_axis_tready falls only while the target sink stalls.
- Header 64 (0x40,0x00) followed by a 60-byte frame -> length_error pulses exactly one cycle after the tlast handshake; the next frame parses normally.
- s_axis_tlast on header beat 0 -> length beat emitted with tlast=1; length_error pulses; no frame-stream output; the following well-formed frame passes.
- rstn low for 3 cycles mid-payload -> all tvalid=0 and frame_length=0 immediately; the next input is parsed as a header.
- Back-to-back frames with REPEAT_NUM=3, all sinks always ready -> zero bubble cycles between frames; three length records and three frames delivered.

Source files
------------

// File: rtl/split_frame_length_pkg.sv
// Shared definitions for the frame-length splitter, merger and pcap utilities.
//   FRAME_LENGTH_WIDTH_DEF : default header width in bits
//   beat_num()             : number of DATA_WIDTH beats that make up the header
//   cnt_width()            : width of a counter spanning the header beats (min 1)
//   state_t                : parser state, HEADER=0, PAYLOAD=1
package split_frame_length_pkg;

  localparam int FRAME_LENGTH_WIDTH_DEF = 16;

  typedef enum logic {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  function automatic int beat_num(input int frame_length_width, input int data_width);
    return frame_length_width / data_width;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/split_frame_length_output_register.sv
// One-entry AXI4-Stream register slice.
//   in_*  : upstream side; in_tready is high when the slot is empty or drains
//           this cycle, so a full-rate stream passes without bubbles.
//   out_* : registered downstream side; data holds until the handshake.
//   clk, rstn : clock and asynchronous active-low reset (clears valid and data).
module axis_output_register #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic [KEEP_WIDTH-1:0] in_tkeep,
  input  logic                  in_tlast,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic [KEEP_WIDTH-1:0] out_tkeep,
  output logic                  out_tlast,
  output logic                  out_tvalid,
  input  logic                  out_tready
);

  logic [DATA_WIDTH-1:0] tdata_p1;
  logic [KEEP_WIDTH-1:0] tkeep_p1;
  logic                  tlast_p1;
  logic                  vld_p1;

  assign in_tready = !vld_p1 || out_tready;

  // Stage p1: single holding register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (in_tvalid && in_tready) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= in_tdata;
      tkeep_p1 <= in_tkeep;
      tlast_p1 <= in_tlast;
    end else if (out_tready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_tdata  = tdata_p1;
  assign out_tkeep  = tkeep_p1;
  assign out_tlast  = tlast_p1;
  assign out_tvalid = vld_p1;

endmodule

// File: rtl/split_frame_length.sv
// Splits a [frame-length header][Ethernet frame] AXI4-Stream into a
// length-only stream and a header-free frame stream, and flags frames whose
// delivered byte count disagrees with the header.
//   s_axis_*                    : merged input stream (tkeep ignored on header beats)
//   m_axis_frame_length_*       : header beats, LSB chunk first, tlast on final beat
//   m_axis_*                    : Ethernet frame, passed through unchanged
//   frame_length                : header value of the current/last frame
//   length_error                : one-cycle pulse on count mismatch or truncated header
//   clk, rstn                   : clock and asynchronous active-low reset
module split_frame_length
  import split_frame_length_pkg::*;
#(
  parameter  int DATA_WIDTH         = 8,
  parameter  int FRAME_LENGTH_WIDTH = FRAME_LENGTH_WIDTH_DEF,
  localparam int KEEP_WIDTH         = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_frame_length_tdata,
  output logic                          m_axis_frame_length_tvalid,
  input  logic                          m_axis_frame_length_tready,
  output logic                          m_axis_frame_length_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [FRAME_LENGTH_WIDTH-1:0] frame_length,
  output logic                          length_error
);

  localparam int FRAME_LENGTH_BEAT_NUM = beat_num(FRAME_LENGTH_WIDTH, DATA_WIDTH);
  localparam int HDR_CNT_W             = cnt_width(FRAME_LENGTH_BEAT_NUM);

  function automatic logic [FRAME_LENGTH_WIDTH-1:0] keep_bytes(input logic [KEEP_WIDTH-1:0] keep);
    logic [FRAME_LENGTH_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) n = n + FRAME_LENGTH_WIDTH'(keep[i]);
    return n;
  endfunction

  // Byte counter sticks at all-ones instead of wrapping, so oversized frames
  // can never alias back onto a small header value.
  function automatic logic [FRAME_LENGTH_WIDTH-1:0] sat_add(
    input logic [FRAME_LENGTH_WIDTH-1:0] a,
    input logic [FRAME_LENGTH_WIDTH-1:0] b
  );
    logic [FRAME_LENGTH_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[FRAME_LENGTH_WIDTH] ? '1 : sum[FRAME_LENGTH_WIDTH-1:0];
  endfunction

  state_t                        state, state_nxt;
  logic [HDR_CNT_W-1:0]          hdr_cnt, hdr_cnt_nxt;
  logic [FRAME_LENGTH_WIDTH-1:0] byte_cnt, byte_cnt_nxt, byte_cnt_sum;
  logic                          err_nxt;
  logic                          hdr_last;
  logic                          s_hs;
  logic                          len_in_rdy, frm_in_rdy;
  logic [0:0]                    len_tkeep_unused;

  // Stage p0: routing, header capture and byte counting
  assign hdr_last      = (hdr_cnt == HDR_CNT_W'(FRAME_LENGTH_BEAT_NUM - 1));
  assign s_axis_tready = (state == HEADER) ? len_in_rdy : frm_in_rdy;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign byte_cnt_sum  = sat_add(byte_cnt, keep_bytes(s_axis_tkeep));

  always_comb begin
    state_nxt    = state;
    hdr_cnt_nxt  = hdr_cnt;
    byte_cnt_nxt = byte_cnt;
    err_nxt      = 1'b0;
    if (s_hs) begin
      if (state == HEADER) begin
        if (s_axis_tlast) begin
          // Truncated header: stay in HEADER and resynchronise on the next beat.
          hdr_cnt_nxt = '0;
          err_nxt     = 1'b1;
        end else if (hdr_last) begin
          hdr_cnt_nxt  = '0;
          byte_cnt_nxt = '0;
          state_nxt    = PAYLOAD;
        end else begin
          hdr_cnt_nxt = hdr_cnt + HDR_CNT_W'(1);
        end
      end else begin
        byte_cnt_nxt = byte_cnt_sum;
        if (s_axis_tlast) begin
          err_nxt     = (byte_cnt_sum != frame_length);
          state_nxt   = HEADER;
          hdr_cnt_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= HEADER;
      hdr_cnt      <= '0;
      byte_cnt     <= '0;
      length_error <= 1'b0;
      frame_length <= '0;
    end else begin
      state        <= state_nxt;
      hdr_cnt      <= hdr_cnt_nxt;
      byte_cnt     <= byte_cnt_nxt;
      length_error <= err_nxt;
      if (s_hs && state == HEADER) begin
        for (int i = 0; i < FRAME_LENGTH_BEAT_NUM; i++) begin
          if (hdr_cnt == HDR_CNT_W'(i)) frame_length[i*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
        end
      end
    end
  end

  // Stage p1: per-stream output registers
  axis_output_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (1)
  ) u_len_reg (
    .clk        (clk),
    .rstn       (rstn),
    .in_tdata   (s_axis_tdata),
    .in_tkeep   (1'b0),
    .in_tlast   (hdr_last || s_axis_tlast),
    .in_tvalid  (s_axis_tvalid && (state == HEADER)),
    .in_tready  (len_in_rdy),
    .out_tdata  (m_axis_frame_length_tdata),
    .out_tkeep  (len_tkeep_unused),
    .out_tlast  (m_axis_frame_length_tlast),
    .out_tvalid (m_axis_frame_length_tvalid),
    .out_tready (m_axis_frame_length_tready)
  );

  axis_output_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_frm_reg (
    .clk        (clk),
    .rstn       (rstn),
    .in_tdata   (s_axis_tdata),
    .in_tkeep   (s_axis_tkeep),
    .in_tlast   (s_axis_tlast),
    .in_tvalid  (s_axis_tvalid && (state == PAYLOAD)),
    .in_tready  (frm_in_rdy),
    .out_tdata  (m_axis_tdata),
    .out_tkeep  (m_axis_tkeep),
    .out_tlast  (m_axis_tlast),
    .out_tvalid (m_axis_tvalid),
    .out_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_split_frame_length.sv
module tb_split_frame_length;
  localparam int DW  = 8;
  localparam int FLW = 16;
  localparam int KW  = DW / 8;
  localparam int HB  = FLW / DW;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic [KW-1:0]  s_axis_tkeep = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [DW-1:0]  m_axis_frame_length_tdata;
  logic           m_axis_frame_length_tvalid;
  logic           m_axis_frame_length_tready = 1'b1;
  logic           m_axis_frame_length_tlast;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [FLW-1:0] frame_length;
  logic           length_error;

  always #5 clk = ~clk;

  split_frame_length dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .s_axis_tdata               (s_axis_tdata),
    .s_axis_tkeep               (s_axis_tkeep),
    .s_axis_tvalid              (s_axis_tvalid),
    .s_axis_tready              (s_axis_tready),
    .s_axis_tlast               (s_axis_tlast),
    .m_axis_frame_length_tdata  (m_axis_frame_length_tdata),
    .m_axis_frame_length_tvalid (m_axis_frame_length_tvalid),
    .m_axis_frame_length_tready (m_axis_frame_length_tready),
    .m_axis_frame_length_tlast  (m_axis_frame_length_tlast),
    .m_axis_tdata               (m_axis_tdata),
    .m_axis_tkeep               (m_axis_tkeep),
    .m_axis_tvalid              (m_axis_tvalid),
    .m_axis_tready              (m_axis_tready),
    .m_axis_tlast               (m_axis_tlast),
    .frame_length               (frame_length),
    .length_error               (length_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  typedef struct packed {
    logic          hdr;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  beat_t             drv_q[$];
  logic [DW:0]       exp_len_q[$];   // {tlast, tdata}
  logic [DW+KW:0]    exp_frm_q[$];   // {tlast, tkeep, tdata}
  bit                exp_err_q[$];   // one entry per input tlast
  int                exp_fl_q[$];    // frame_length after that tlast, -1 = don't care

  // Reference: build input beats plus expected outputs from the frame description.
  task automatic queue_frame(input int declared, input int plen, input bit trunc, input bit rand_keep);
    logic [FLW-1:0] d;
    beat_t b;
    int nbytes;
    d = declared[FLW-1:0];
    nbytes = 0;
    if (trunc) begin
      b = '{hdr: 1'b1, last: 1'b1, keep: KW'($urandom), data: d[DW-1:0]};
      drv_q.push_back(b);
      exp_len_q.push_back({1'b1, d[DW-1:0]});
      exp_err_q.push_back(1'b1);
      exp_fl_q.push_back(-1);
      return;
    end
    for (int i = 0; i < HB; i++) begin
      b = '{hdr: 1'b1, last: 1'b0, keep: KW'($urandom), data: d[i*DW +: DW]};
      drv_q.push_back(b);
      exp_len_q.push_back({(i == HB - 1), d[i*DW +: DW]});
    end
    for (int i = 0; i < plen; i++) begin
      b.hdr  = 1'b0;
      b.last = (i == plen - 1);
      b.keep = rand_keep ? KW'($urandom_range(7) != 0) : '1;
      b.data = DW'($urandom);
      drv_q.push_back(b);
      exp_frm_q.push_back({b.last, b.keep, b.data});
      for (int k = 0; k < KW; k++) nbytes += int'(b.keep[k]);
    end
    exp_err_q.push_back(nbytes != declared);
    exp_fl_q.push_back(declared);
  endtask

  bit cur_hdr = 1'b0;

  // Called at posedge+#1; returns at posedge+#1 after the last accepted beat.
  task automatic drive(input int max_beats, input int gap_pct);
    int n;
    int w;
    beat_t b;
    n = 0;
    while (drv_q.size() > 0 && n < max_beats) begin
      b = drv_q.pop_front();
      if (gap_pct > 0) begin
        while ($urandom_range(99) < gap_pct) begin
          s_axis_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tvalid = 1'b1;
      cur_hdr       = b.hdr;
      w = 0;
      @(negedge clk);
      while (!s_axis_tready) begin
        w++;
        if (w > 5000) begin
          check_eq("drive_timeout", 1, 0);
          finish_tb();
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_len_q.size() + exp_frm_q.size() + exp_err_q.size()) != 0 && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain_len", exp_len_q.size(), 0);
    check_eq("drain_frm", exp_frm_q.size(), 0);
    check_eq("drain_err", exp_err_q.size(), 0);
  endtask

  // Sink behaviour: 0 always ready, 1 random, 2 frame sink toggles every 50
  // cycles while the length sink starts 20 cycles low.
  int sink_mode = 0;
  int sink_cyc = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk); #1;
      sink_cyc++;
      case (sink_mode)
        1: begin
          m_axis_tready              = ($urandom_range(99) < 70);
          m_axis_frame_length_tready = ($urandom_range(99) < 70);
        end
        2: begin
          m_axis_tready              = ((sink_cyc / 50) % 2) == 0;
          m_axis_frame_length_tready = (sink_cyc >= 20);
        end
        default: begin
          m_axis_tready              = 1'b1;
          m_axis_frame_length_tready = 1'b1;
        end
      endcase
    end
  end

  bit          mon_en = 1'b0;
  bit          exp_err_now = 1'b0;
  int          fl_chk_now = -1;
  logic [DW:0]    e_len;
  logic [DW+KW:0] e_frm;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("length_error", length_error, exp_err_now);
      if (fl_chk_now >= 0) check_eq("frame_length", frame_length, fl_chk_now);
      exp_err_now = 1'b0;
      fl_chk_now  = -1;
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
        if (exp_err_q.size() == 0) check_eq("err_q_underflow", 1, 0);
        else begin
          exp_err_now = exp_err_q.pop_front();
          fl_chk_now  = exp_fl_q.pop_front();
        end
      end
      if (m_axis_frame_length_tvalid && m_axis_frame_length_tready) begin
        if (exp_len_q.size() == 0) check_eq("len_unexpected", 1, 0);
        else begin
          e_len = exp_len_q.pop_front();
          check_eq("len_beat", {m_axis_frame_length_tlast, m_axis_frame_length_tdata}, e_len);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_frm_q.size() == 0) check_eq("frm_unexpected", 1, 0);
        else begin
          e_frm = exp_frm_q.pop_front();
          check_eq("frm_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e_frm);
        end
      end
      if (s_axis_tvalid && !s_axis_tready)
        check_eq("stall_cause", cur_hdr ? m_axis_frame_length_tready : m_axis_tready, 0);
    end
  end

  initial begin
    int c0;
    int plen;
    int decl;
    int nb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_len_tvalid", m_axis_frame_length_tvalid, 0);
    check_eq("rst_frm_tvalid", m_axis_tvalid, 0);
    check_eq("rst_frm_tdata", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
    check_eq("rst_frame_length", frame_length, 0);
    check_eq("rst_length_error", length_error, 0);
    check_eq("rst_s_tready", s_axis_tready, 1);
    rstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // 1518-byte frame, header 0xEE,0x05
    sink_mode = 0;
    queue_frame(1518, 1518, 1'b0, 1'b0);
    drive(1 << 30, 0);
    drain();

    // Same traffic under sink stalls
    sink_cyc = 0;
    sink_mode = 2;
    queue_frame(1518, 1518, 1'b0, 1'b0);
    drive(1 << 30, 0);
    drain();
    sink_mode = 0;

    // Header 64 with only 60 bytes, then a well-formed frame
    queue_frame(64, 60, 1'b0, 1'b0);
    queue_frame(60, 60, 1'b0, 1'b0);
    drive(1 << 30, 0);
    drain();

    // Truncated header on beat 0, then a well-formed frame
    queue_frame(100, 0, 1'b1, 1'b0);
    queue_frame(30, 30, 1'b0, 1'b0);
    drive(1 << 30, 0);
    drain();

    // Randomised frames, gaps and back-pressure
    sink_mode = 1;
    for (int f = 0; f < 10; f++) begin
      plen = $urandom_range(1, 120);
      decl = ($urandom_range(3) == 0) ? plen + $urandom_range(1, 3) : plen;
      queue_frame(decl, plen, ($urandom_range(5) == 0), $urandom_range(1));
    end
    drive(1 << 30, 20);
    drain();
    sink_mode = 0;

    // Reset in the middle of a payload
    queue_frame(100, 100, 1'b0, 1'b0);
    drive(30, 0);
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    check_eq("midrst_len_tvalid", m_axis_frame_length_tvalid, 0);
    check_eq("midrst_frm_tvalid", m_axis_tvalid, 0);
    check_eq("midrst_frame_length", frame_length, 0);
    check_eq("midrst_length_error", length_error, 0);
    drv_q.delete();
    exp_len_q.delete();
    exp_frm_q.delete();
    exp_err_q.delete();
    exp_fl_q.delete();
    exp_err_now = 1'b0;
    fl_chk_now = -1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;
    queue_frame(20, 20, 1'b0, 1'b0);
    drive(1 << 30, 0);
    drain();

    // Back-to-back frames with every sink ready: one beat per cycle
    nb = 0;
    for (int f = 0; f < 3; f++) begin
      queue_frame(40 + f, 40 + f, 1'b0, 1'b0);
      nb += HB + 40 + f;
    end
    c0 = cyc;
    drive(1 << 30, 0);
    check_eq("b2b_cycles", cyc - c0, nb);
    drain();

    finish_tb();
  end

endmodule
